// File: rtl/j17_isa_pkg.sv
// J17 instruction-set constants shared by the fetch/decode front end.
// Holds opcode values, pcControl codes, field positions, FSM states and fault codes.
package j17_isa_pkg;

    localparam logic [4:0] OP_ALU_FIRST = 5'd0;
    localparam logic [4:0] OP_ADD       = 5'd1;
    localparam logic [4:0] OP_ALU_LAST  = 5'd11;
    localparam logic [4:0] OP_MOV       = 5'd12;
    localparam logic [4:0] OP_BR_BASE   = 5'd12;
    localparam logic [4:0] OP_BR_FIRST  = 5'd13;
    localparam logic [4:0] OP_BR_LAST   = 5'd21;
    localparam logic [4:0] OP_HALT      = 5'd22;

    localparam logic [4:0] PC_NEXT   = 5'd0;
    localparam logic [4:0] PC_BUBBLE = 5'd10;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int OP1_MSB   = 26;
    localparam int OP1_LSB   = 24;
    localparam int OP2_MSB   = 23;
    localparam int OP2_LSB   = 3;
    localparam int IMC_BIT   = 2;
    localparam int FLAG_BIT  = 1;
    localparam int FLAG1_BIT = 0;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } fd_state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b10;

endpackage

// File: rtl/j17_decoder.sv
// Combinational decode of one J17 instruction word into the DP control bundle.
module j17_decoder
    import j17_isa_pkg::*;
(
    input  logic [31:0] word,
    output logic [4:0]  alucode,
    output logic [2:0]  op1,
    output logic [20:0] op2,
    output logic        imControl,
    output logic        flag,
    output logic        flag1,
    output logic [4:0]  pcControl,
    output logic        writecode,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [4:0] opcode;

    assign opcode = word[OPC_MSB:OPC_LSB];

    always_comb begin
        alucode    = 5'd0;
        op1        = word[OP1_MSB:OP1_LSB];
        op2        = word[OP2_MSB:OP2_LSB];
        imControl  = word[IMC_BIT];
        flag       = word[FLAG_BIT];
        flag1      = word[FLAG1_BIT];
        pcControl  = PC_NEXT;
        writecode  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (opcode <= OP_ALU_LAST) begin
            alucode = opcode;
        end else if (opcode == OP_MOV) begin
            writecode = 1'b1;
        end else if (opcode <= OP_BR_LAST) begin
            // Branch/jump opcodes map onto pcControl 1..9.
            pcControl = opcode - OP_BR_BASE;
        end else if (opcode == OP_HALT) begin
            is_halt   = 1'b1;
            pcControl = PC_BUBBLE;
        end else begin
            is_illegal = 1'b1;
            pcControl  = PC_BUBBLE;
        end
    end

endmodule

// File: rtl/j17_fetch_decode.sv
// J17 fetch/decode front end: fetches a word at PC, waits for the acknowledge,
// and presents the decoded controls to DP for exactly one EXEC cycle.
module j17_fetch_decode
    import j17_isa_pkg::*;
#(
    parameter int IMEM_AW     = 10,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [31:0]        PC,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [31:0]        imem_data,
    output logic [4:0]         alucode,
    output logic [2:0]         op1,
    output logic [20:0]        op2,
    output logic               imControl,
    output logic               flag,
    output logic               flag1,
    output logic [4:0]         pcControl,
    output logic               writecode,
    output logic [31:0]        instr_count,
    output logic               halted,
    output logic [1:0]         fault
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

    fd_state_t   state;
    logic [TW-1:0] ack_timer;

    logic [4:0]  dec_alucode;
    logic [2:0]  dec_op1;
    logic [20:0] dec_op2;
    logic        dec_imControl;
    logic        dec_flag;
    logic        dec_flag1;
    logic [4:0]  dec_pcControl;
    logic        dec_writecode;
    logic        dec_halt;
    logic        dec_illegal;
    logic        unused_pc_bits;

    assign imem_addr      = PC[IMEM_AW-1:0];
    assign unused_pc_bits = ^PC[31:IMEM_AW];

    j17_decoder u_decoder (
        .word       (imem_data),
        .alucode    (dec_alucode),
        .op1        (dec_op1),
        .op2        (dec_op2),
        .imControl  (dec_imControl),
        .flag       (dec_flag),
        .flag1      (dec_flag1),
        .pcControl  (dec_pcControl),
        .writecode  (dec_writecode),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    // Controls default to a bubble every cycle; only a legal acknowledged word
    // loads them, so they are live for exactly the following EXEC cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_FETCH;
            ack_timer   <= '0;
            imem_req    <= 1'b1;
            alucode     <= 5'd0;
            op1         <= 3'd0;
            op2         <= 21'd0;
            imControl   <= 1'b0;
            flag        <= 1'b0;
            flag1       <= 1'b0;
            pcControl   <= PC_BUBBLE;
            writecode   <= 1'b0;
            instr_count <= 32'd0;
            halted      <= 1'b0;
            fault       <= FAULT_NONE;
        end else begin
            alucode   <= 5'd0;
            op1       <= 3'd0;
            op2       <= 21'd0;
            imControl <= 1'b0;
            flag      <= 1'b0;
            flag1     <= 1'b0;
            pcControl <= PC_BUBBLE;
            writecode <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ack_timer <= '0;
                        imem_req  <= 1'b0;
                        if (dec_illegal) begin
                            state <= ST_FAULT;
                            fault <= FAULT_ILLEGAL;
                        end else if (dec_halt) begin
                            state  <= ST_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state     <= ST_EXEC;
                            alucode   <= dec_alucode;
                            op1       <= dec_op1;
                            op2       <= dec_op2;
                            imControl <= dec_imControl;
                            flag      <= dec_flag;
                            flag1     <= dec_flag1;
                            pcControl <= dec_pcControl;
                            writecode <= dec_writecode;
                        end
                    end else if (ack_timer == TIMEOUT_LAST) begin
                        state    <= ST_FAULT;
                        fault    <= FAULT_TIMEOUT;
                        imem_req <= 1'b0;
                    end else begin
                        ack_timer <= ack_timer + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (instr_count != 32'hFFFF_FFFF) begin
                        instr_count <= instr_count + 32'd1;
                    end
                    state     <= ST_FETCH;
                    ack_timer <= '0;
                    imem_req  <= 1'b1;
                end
                ST_HALTED, ST_FAULT: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_j17_fetch_decode.sv
// Directed self-checking bench for j17_fetch_decode with hand-computed expectations.
module tb_j17_fetch_decode;

    logic        clock;
    logic        reset_n;
    logic [31:0] PC;
    logic [9:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [4:0]  alucode;
    logic [2:0]  op1;
    logic [20:0] op2;
    logic        imControl;
    logic        flag;
    logic        flag1;
    logic [4:0]  pcControl;
    logic        writecode;
    logic [31:0] instr_count;
    logic        halted;
    logic [1:0]  fault;

    int compared   = 0;
    int mismatched = 0;

    j17_fetch_decode #(.IMEM_AW(10), .ACK_TIMEOUT(255)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .PC          (PC),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .alucode     (alucode),
        .op1         (op1),
        .op2         (op2),
        .imControl   (imControl),
        .flag        (flag),
        .flag1       (flag1),
        .pcControl   (pcControl),
        .writecode   (writecode),
        .instr_count (instr_count),
        .halted      (halted),
        .fault       (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] data);
        imem_ack  = ack;
        imem_data = data;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Acknowledge in the current FETCH cycle and land in the EXEC cycle.
    task automatic execOne(input logic [31:0] word);
        applyStimulus(1'b1, word);
        tick();
        applyStimulus(1'b0, 32'd0);
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, "_pc"}, 32'(pcControl), 32'd10);
        checkOutput({tag, "_ctl"}, {alucode, op1, imControl, flag, flag1, writecode}, 32'd0);
        checkOutput({tag, "_op2"}, 32'(op2), 32'd0);
    endtask

    task automatic resetRelease(input logic [31:0] newPc);
        PC = newPc;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        PC = 32'h0000_0100;
        applyStimulus(1'b0, 32'd0);

        // Asynchronous reset before any clock edge
        #2 reset_n = 1'b0;
        #2;
        checkBubble("rst");
        checkOutput("rst_count", instr_count, 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_req", 32'(imem_req), 32'd1);
        resetRelease(32'h0000_0100);
        checkOutput("rel_req", 32'(imem_req), 32'd1);
        checkOutput("rel_addr", 32'(imem_addr), 32'h100);

        // ADD r2,r5 with immediate acknowledge
        execOne(32'h0AA0_0000);
        checkOutput("add_alu", 32'(alucode), 32'd1);
        checkOutput("add_op1", 32'(op1), 32'd2);
        checkOutput("add_op2hi", 32'(op2[20:18]), 32'd5);
        checkOutput("add_pc", 32'(pcControl), 32'd0);
        checkOutput("add_imc", 32'(imControl), 32'd0);
        checkOutput("add_cnt0", instr_count, 32'd0);
        tick();
        checkOutput("add_cnt1", instr_count, 32'd1);
        checkBubble("add_after");
        checkOutput("add_req", 32'(imem_req), 32'd1);
        PC = 32'h0000_0104;
        #1;
        checkOutput("addr_new", 32'(imem_addr), 32'h104);

        // ADDI r1,#-3 with acknowledge in the 4th request cycle
        for (int i = 0; i < 3; i++) begin
            checkOutput("addi_req", 32'(imem_req), 32'd1);
            checkOutput("addi_addr", 32'(imem_addr), 32'h104);
            checkOutput("addi_pc", 32'(pcControl), 32'd10);
            tick();
        end
        checkOutput("addi_req4", 32'(imem_req), 32'd1);
        execOne(32'h09FF_FFEC);
        checkOutput("addi_imc", 32'(imControl), 32'd1);
        checkOutput("addi_op2", 32'(op2), 32'h1F_FFFD);
        checkOutput("addi_op1", 32'(op1), 32'd1);
        checkOutput("addi_pcc", 32'(pcControl), 32'd0);
        tick();
        checkOutput("addi_cnt", instr_count, 32'd2);
        PC = 32'h0000_0108;

        // MOV r3 with both flags set
        execOne(32'h6300_0003);
        checkOutput("mov_wr", 32'(writecode), 32'd1);
        checkOutput("mov_alu", 32'(alucode), 32'd0);
        checkOutput("mov_pcc", 32'(pcControl), 32'd0);
        checkOutput("mov_op1", 32'(op1), 32'd3);
        checkOutput("mov_flags", {flag, flag1}, 32'd3);
        tick();

        // Branch boundaries: opcode 13 -> 1, opcode 21 -> 9
        execOne(32'h6800_0000);
        checkOutput("br13_pcc", 32'(pcControl), 32'd1);
        checkOutput("br13_alu", 32'(alucode), 32'd0);
        tick();
        execOne(32'hA800_0000);
        checkOutput("br21_pcc", 32'(pcControl), 32'd9);
        checkOutput("br21_wr", 32'(writecode), 32'd0);
        tick();

        // Last ALU opcode 11
        execOne(32'h5800_0000);
        checkOutput("alu11", 32'(alucode), 32'd11);
        checkOutput("alu11_pcc", 32'(pcControl), 32'd0);
        tick();
        checkOutput("cnt6", instr_count, 32'd6);

        // Acknowledge arriving in the 255th FETCH cycle still executes
        for (int i = 0; i < 254; i++) tick();
        checkOutput("ack255_fault", 32'(fault), 32'd0);
        checkOutput("ack255_req", 32'(imem_req), 32'd1);
        execOne(32'h0AA0_0000);
        checkOutput("ack255_pcc", 32'(pcControl), 32'd0);
        checkOutput("ack255_alu", 32'(alucode), 32'd1);
        checkOutput("ack255_flt", 32'(fault), 32'd0);
        tick();
        checkOutput("cnt7", instr_count, 32'd7);

        // HALT: no EXEC, no count, later acknowledges ignored
        execOne(32'hB000_0000);
        checkOutput("halt_h", 32'(halted), 32'd1);
        checkOutput("halt_req", 32'(imem_req), 32'd0);
        checkBubble("halt");
        applyStimulus(1'b1, 32'h0AA0_0000);
        tick();
        tick();
        applyStimulus(1'b0, 32'd0);
        checkOutput("halt_cnt", instr_count, 32'd7);
        checkOutput("halt_hold", 32'(halted), 32'd1);
        checkOutput("halt_pcc", 32'(pcControl), 32'd10);

        // Reset out of HALTED, run one ADD, then pulse reset mid FETCH wait
        reset_n = 1'b0;
        #1;
        checkOutput("rst2_halted", 32'(halted), 32'd0);
        resetRelease(32'h0000_0100);
        tick();
        execOne(32'h0AA0_0000);
        tick();
        checkOutput("pre_rst_cnt", instr_count, 32'd1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checkBubble("midrst");
        checkOutput("midrst_cnt", instr_count, 32'd0);
        checkOutput("midrst_flt", 32'(fault), 32'd0);
        resetRelease(32'h0000_0200);
        checkOutput("restart_req", 32'(imem_req), 32'd1);
        checkOutput("restart_addr", 32'(imem_addr), 32'h200);

        // No acknowledge: timeout fault after exactly 255 FETCH cycles
        for (int i = 0; i < 254; i++) tick();
        checkOutput("to254_flt", 32'(fault), 32'd0);
        checkOutput("to254_req", 32'(imem_req), 32'd1);
        tick();
        checkOutput("to_flt", 32'(fault), 32'd1);
        checkOutput("to_req", 32'(imem_req), 32'd0);
        checkBubble("to");

        // Illegal opcode 31 after one counted instruction
        reset_n = 1'b0;
        #1;
        resetRelease(32'h0000_0100);
        execOne(32'h0AA0_0000);
        tick();
        execOne(32'hF800_0000);
        checkOutput("ill_flt", 32'(fault), 32'd2);
        checkBubble("ill");
        checkOutput("ill_req", 32'(imem_req), 32'd0);
        applyStimulus(1'b1, 32'h0AA0_0000);
        tick();
        tick();
        applyStimulus(1'b0, 32'd0);
        checkOutput("ill_hold", 32'(fault), 32'd2);
        checkOutput("ill_cnt", instr_count, 32'd1);
        checkOutput("ill_pcc", 32'(pcControl), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/j17_fetch_decode.md
# j17_fetch_decode

Instruction fetch/decode front end for the J17 core, sitting directly upstream of the `DP` datapath. It fetches a 32-bit instruction word from instruction memory at the address given by DP's `PC`, waits for a variable-latency acknowledge, and decodes the word into DP's control bundle for exactly one execute cycle. In every other cycle it drives a bubble (`pcControl`=10), under which DP neither writes nor advances `PC`.

## Interface
- `IMEM_AW`, 10: instruction memory address width.
- `ACK_TIMEOUT`, 255: maximum cycles in FETCH without an acknowledge before a fault is raised.

- `clock` in 1: core clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `PC` in 32: program counter from DP.
- `imem_addr` out `IMEM_AW`: fetch address.
- `imem_req` out 1: fetch request.
- `imem_ack` in 1: fetch data valid.
- `imem_data` in 32: instruction word.
- `alucode` out 5: to DP.
- `op1` out 3: to DP.
- `op2` out 21: to DP.
- `imControl` out 1: to DP.
- `flag` out 1: to DP.
- `flag1` out 1: to DP.
- `pcControl` out 5: to DP.
- `writecode` out 1: to DP.
- `instr_count` out 32: retired-instruction count.
- `halted` out 1: HALT executed.
- `fault` out 2: 00 none, 01 fetch timeout, 10 illegal opcode.

## Operation
- Instruction format:
  - [31:27] opcode
  - [26:24] op1
  - [23:3] op2
  - [2] imControl
  - [1] flag
  - [0] flag1
- Decode rules:
  - Opcodes 0–11: `alucode`=opcode, `pcControl`=0, `writecode`=0.
  - Opcode 12 (MOV): `alucode`=0, `pcControl`=0, `writecode`=1.
  - Opcodes 13–21 (branch/jump): `pcControl`=opcode−12 (1..9), `alucode`=0, `writecode`=0.
  - Opcode 22: HALT.
  - Opcodes 23–31: illegal.
- Bubble: `pcControl`=10 and all other control outputs 0.
- FSM states: FETCH, EXEC, HALTED, FAULT.
  - FETCH: `imem_req`=1, bubble driven.
    - At the edge where `imem_ack`=1: latch and decode `imem_data` into registered controls.
    - Next state is EXEC for a legal opcode, HALTED for HALT, FAULT (10) for an illegal opcode.
  - EXEC: the decoded controls are valid for exactly one cycle and DP consumes them at the ending edge. `instr_count` increments, saturating at 0xFFFFFFFF. Next state is FETCH.
  - HALTED: `halted`=1, bubble driven, `imem_req`=0. Left only via reset.
  - FAULT: `fault` code held, bubble driven, `imem_req`=0. Left only via reset.
- Timeout counter: cleared on entry to FETCH, incremented each FETCH cycle without an acknowledge. When it reaches `ACK_TIMEOUT`, go to FAULT with code 01. If an acknowledge arrives in the same cycle, the acknowledge wins.
- `imem_addr` = `PC[IMEM_AW-1:0]` (combinational). It is stable through FETCH because bubbles hold `PC`.
- HALT and illegal words are never counted and never produce an EXEC cycle.
- `imem_ack` outside FETCH is ignored.

## Timing
- Reset state (asynchronous, on `reset_n`=0):
  - state FETCH
  - bubble on all control outputs
  - `instr_count`=0, `halted`=0, `fault`=00, timeout counter 0
- `imem_req` is high in the first cycle after reset is released.
- Minimum cost per instruction is 2 cycles: FETCH with an immediate acknowledge, then EXEC.
- An acknowledge arriving N cycles after the request gives N+2 cycles per instruction.
- The new `PC` appears in the FETCH cycle following EXEC, so `imem_addr` changes that cycle.
- All control outputs are registered and glitch-free into DP.
- Reset asserted mid-FETCH or mid-EXEC takes effect immediately, with no partial EXEC. A pending acknowledge is discarded.

## Structure
- Package `j17_isa_pkg`:
  - opcode constants (OP_ADD…OP_HALT)
  - `pcControl` codes, including PC_BUBBLE=10
  - field bit positions
  - FSM state enum
  - fault codes
- Sub-module `j17_decoder`: combinational mapping from a 32-bit word to the control bundle plus `is_halt` and `is_illegal`. It is instantiated once.
- `j17_fetch_decode` holds the FSM, the control registers, the timeout counter and the retire counter.

## Test plan
- ADD r2,r5 (0x0AA00000), acknowledge same cycle as request:
  - EXEC cycle shows `alucode`=1, `op1`=2, `op2[20:18]`=5, `pcControl`=0, `imControl`=0.
  - `instr_count` goes 0→1.
  - Bubble in the following cycle.
- ADDI r1,#−3 (0x09FFFFEC), acknowledge delayed 3 cycles:
  - `imem_req` is high for 4 cycles with `imem_addr` stable.
  - EXEC shows `imControl`=1 and `op2`=0x1FFFFD.
- HALT (0xB0000000):
  - No EXEC cycle; `halted`=1 thereafter and `imem_req`=0.
  - `instr_count` unchanged.
  - Further acknowledges are ignored.
- Illegal opcode 31 (0xF8000000): `fault`=10, bubble held, no count increment.
- No acknowledge for 255 cycles: `fault`=01 after exactly `ACK_TIMEOUT` cycles. A separate case with the acknowledge in cycle 255 must reach EXEC, not FAULT.
- `reset_n` pulsed low during FETCH wait:
  - Bubble driven immediately and all counters zero.
  - After release, the fetch restarts with `imem_req`=1 at the current `PC`.
